mux16_arbiter: RTL and testbench

MUX16_ARBITER -- requirements
Module: mux16_arbiter

---
 rtl/mux16_arbiter.sv | 135 +++++++++++++
 tb/tb_mux16_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux16_arbiter.sv
// Round-robin 16:1 arbiter with a registered output word and a one-hot grant.
// Defining MUX16_ARBITER_LOCK_EN adds a lock input that keeps the grant on a busy requester.
module mux16_arbiter #(
    parameter int bits = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       req,
    input  logic [16*bits-1:0] in_data,
    input  logic              out_ready,
`ifdef MUX16_ARBITER_LOCK_EN
    input  logic              lock,
`endif
    output logic [15:0]       grant,
    output logic [3:0]        select,
    output logic [15:0]       ack,
    output logic              out_valid,
    output logic [bits-1:0]   out_data
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [3:0]        ptr;
    logic [3:0]        ptr_n;
    logic [3:0]        select_n;
    logic [15:0]       grant_n;
    logic              out_valid_n;
    logic [bits-1:0]   out_data_n;

    logic              xfer;
    logic              lock_hit;
    logic [3:0]        arb_ptr;
    logic [15:0]       arb_req;
    logic [3:0]        idx;
    logic [3:0]        win;
    logic              found;

    assign xfer = (state == BUSY) && out_ready;

`ifdef MUX16_ARBITER_LOCK_EN
    assign lock_hit = lock && req[select];
`else
    assign lock_hit = 1'b0;
`endif

    // On a transfer the pointer moves past the acked requester and it sits out this round.
    assign arb_ptr = xfer ? (select + 4'd1) : ptr;
    assign arb_req = xfer ? (req & ~grant) : req;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 16; k++) begin
            idx = arb_ptr + 4'(k);
            if (!found && arb_req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            select    <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            select    <= select_n;
            grant     <= grant_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        select_n    = select;
        grant_n     = grant;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n     = BUSY;
                    select_n    = win;
                    grant_n     = 16'(1) << win;
                    out_valid_n = 1'b1;
                    out_data_n  = in_data[int'(win)*bits +: bits];
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (lock_hit) begin
                        out_data_n = in_data[int'(select)*bits +: bits];
                    end else begin
                        ptr_n = select + 4'd1;
                        if (found) begin
                            select_n   = win;
                            grant_n    = 16'(1) << win;
                            out_data_n = in_data[int'(win)*bits +: bits];
                        end else begin
                            state_n     = IDLE;
                            grant_n     = '0;
                            out_valid_n = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Ack is suppressed while reset is asserted so a discarded word is never consumed.
    always_comb begin
        ack = '0;
        if (out_valid && out_ready && !reset) begin
            ack = grant;
        end
    end

endmodule

// File: tb/tb_mux16_arbiter.sv
// Bench for mux16_arbiter: directed table, corner sequences, randomized model check.
module tb_mux16_arbiter;

    localparam int B = 8;

    logic           clock;
    logic           reset;
    logic [15:0]    req;
    logic [16*B-1:0] in_data;
    logic           out_ready;
    logic [15:0]    grant;
    logic [3:0]     select;
    logic [15:0]    ack;
    logic           out_valid;
    logic [B-1:0]   out_data;

    int total = 0;
    int bad   = 0;

    mux16_arbiter #(.bits(B)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .in_data   (in_data),
        .out_ready (out_ready),
        .grant     (grant),
        .select    (select),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [15:0] rq;
        logic        rdy;
        logic [15:0] exp_ack;
        logic        exp_valid;
        logic [3:0]  exp_sel;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [7:0] word_of(int i);
        return 8'(i * 17);
    endfunction

    function automatic int pick(logic [15:0] r, int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic r, logic [15:0] q, logic y);
        reset     = r;
        req       = q;
        out_ready = y;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_words();
        for (int i = 0; i < 16; i++) in_data[i*B +: B] = word_of(i);
    endtask

    logic       m_valid;
    int         m_sel;
    int         m_ptr;
    logic [7:0] m_data;
    logic [7:0] held;

    initial begin
        reset = 1'b1;
        req = '0;
        out_ready = 1'b0;
        fill_words();

        vecs[0]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 16'h0001, 1'b1, 16'h0000, 1'b1, 4'd0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 4'd0};
        vecs[3]  = '{1'b0, 16'h4000, 1'b0, 16'h0000, 1'b1, 4'd14};
        vecs[4]  = '{1'b0, 16'h8001, 1'b1, 16'h4000, 1'b1, 4'd15};
        vecs[5]  = '{1'b0, 16'h8001, 1'b1, 16'h8000, 1'b1, 4'd0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 4'd0};
        vecs[7]  = '{1'b0, 16'h0020, 1'b0, 16'h0000, 1'b1, 4'd5};
        vecs[8]  = '{1'b1, 16'h0020, 1'b1, 16'h0000, 1'b0, 4'd0};
        vecs[9]  = '{1'b0, 16'h0030, 1'b0, 16'h0000, 1'b1, 4'd4};
        vecs[10] = '{1'b0, 16'h0030, 1'b1, 16'h0010, 1'b1, 4'd5};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 16'h0020, 1'b0, 4'd5};

        for (int v = 0; v < 12; v++) begin
            drive(vecs[v].rst, vecs[v].rq, vecs[v].rdy);
            #2;
            check($sformatf("vec%0d ack", v), 32'(ack), 32'(vecs[v].exp_ack));
            tick();
            check($sformatf("vec%0d valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d grant", v), 32'(grant),
                  vecs[v].exp_valid ? (32'd1 << vecs[v].exp_sel) : 32'd0);
            if (vecs[v].exp_valid || vecs[v].rst) begin
                check($sformatf("vec%0d select", v), 32'(select), 32'(vecs[v].exp_sel));
                check($sformatf("vec%0d data", v), 32'(out_data),
                      vecs[v].rst ? 32'd0 : 32'(word_of(int'(vecs[v].exp_sel))));
            end
        end

        // Full request load: rotation 0..15 then wrap, no bubble.
        drive(1'b1, 16'h0000, 1'b0);
        tick();
        for (int k = 0; k <= 16; k++) begin
            drive(1'b0, 16'hFFFF, 1'b1);
            tick();
            check($sformatf("rot%0d select", k), 32'(select), 32'(k % 16));
            check($sformatf("rot%0d valid", k), 32'(out_valid), 32'd1);
            check($sformatf("rot%0d data", k), 32'(out_data), 32'(word_of(k % 16)));
        end

        // Stalled consumer: grant to 5 holds while inputs churn.
        drive(1'b1, 16'h0000, 1'b0);
        tick();
        drive(1'b0, 16'h0020, 1'b0);
        tick();
        check("stall select0", 32'(select), 32'd5);
        held = out_data;
        for (int k = 0; k < 10; k++) begin
            req = 16'($urandom);
            for (int i = 0; i < 16; i++) in_data[i*B +: B] = 8'($urandom);
            #2;
            check($sformatf("stall%0d ack", k), 32'(ack), 32'd0);
            tick();
            check($sformatf("stall%0d select", k), 32'(select), 32'd5);
            check($sformatf("stall%0d data", k), 32'(out_data), 32'(held));
            check($sformatf("stall%0d valid", k), 32'(out_valid), 32'd1);
        end
        fill_words();

        // Randomized run against a behavioural model.
        drive(1'b1, 16'h0000, 1'b0);
        tick();
        m_valid = 1'b0;
        m_sel = 0;
        m_ptr = 0;
        m_data = '0;
        for (int c = 0; c < 600; c++) begin
            logic [15:0] rq;
            logic [15:0] pend;
            logic        rs;
            logic        rd;
            int          w;
            rs = ($urandom_range(0, 49) == 0);
            rd = ($urandom_range(0, 2) != 0);
            rq = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 4) == 0) rq = '0;
            for (int i = 0; i < 16; i++) in_data[i*B +: B] = 8'($urandom);
            drive(rs, rq, rd);
            #2;
            check("rand ack", 32'(ack),
                  (m_valid && rd && !rs) ? (32'd1 << m_sel) : 32'd0);
            if (rs) begin
                m_valid = 1'b0;
                m_sel = 0;
                m_ptr = 0;
                m_data = '0;
            end else if (!m_valid) begin
                w = pick(rq, m_ptr);
                if (w >= 0) begin
                    m_valid = 1'b1;
                    m_sel = w;
                    m_data = in_data[w*B +: B];
                end
            end else if (rd) begin
                m_ptr = (m_sel + 1) % 16;
                pend = rq;
                pend[m_sel] = 1'b0;
                w = pick(pend, m_ptr);
                if (w >= 0) begin
                    m_sel = w;
                    m_data = in_data[w*B +: B];
                end else begin
                    m_valid = 1'b0;
                end
            end
            tick();
            check("rand valid", 32'(out_valid), 32'(m_valid));
            check("rand grant", 32'(grant), m_valid ? (32'd1 << m_sel) : 32'd0);
            if (m_valid || rs) begin
                check("rand select", 32'(select), 32'(m_sel));
                check("rand data", 32'(out_data), 32'(m_data));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
